// File: rtl/soc_cpu_mult_pkg.sv
// Shared definitions for the CPU multiply unit: op encoding and pipeline depth.
package soc_cpu_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXSS = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXUU = 2'd3
    } mult_op_e;

    localparam int MULT_LATENCY = 2;

endpackage

// File: rtl/soc_cpu_mult_partial.sv
// Unsigned HALF_W x HALF_W multiplier; the product register loads only when en is high.
module soc_cpu_mult_partial #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [HALF_W-1:0]     a,
    input  logic [HALF_W-1:0]     b,
    output logic [2*HALF_W-1:0]   p
);

    always_ff @(posedge clk) begin
        if (en) begin
            p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
        end
    end

endmodule

// File: rtl/soc_cpu_mult_unit.sv
// Two-stage pipelined multiplier (MUL / MULX high words) with a global stall.
// High-word ops are built only when SOC_CPU_MULT_UNIT_HI_EN is defined; otherwise ops 1-3 flag out_err.
module soc_cpu_mult_unit
    import soc_cpu_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int H = DATA_W / 2;

    logic                advance;
    logic                take;
    logic                s1_valid;
    mult_op_e            s1_op;
    logic [TAG_W-1:0]    s1_tag;
    logic [DATA_W-1:0]   pp_ll;
    logic [DATA_W-1:0]   pp_lh;
    logic [DATA_W-1:0]   pp_hl;
    logic [DATA_W-1:0]   pp_hh;
    logic [DATA_W:0]     cross_sum;
    logic [2*DATA_W-1:0] prod_raw;
    logic [DATA_W-1:0]   sel_word;
    logic                s2_valid;
    logic [DATA_W-1:0]   s2_result;
    logic [TAG_W-1:0]    s2_tag;

    assign advance  = ~s2_valid | out_ready;
    assign in_ready = advance & ~reset;
    assign take     = in_valid & in_ready;

    soc_cpu_mult_partial #(.HALF_W(H)) u_pp_ll (
        .clk(clk), .en(advance), .a(in_src1[H-1:0]), .b(in_src2[H-1:0]), .p(pp_ll)
    );
    soc_cpu_mult_partial #(.HALF_W(H)) u_pp_lh (
        .clk(clk), .en(advance), .a(in_src1[H-1:0]), .b(in_src2[DATA_W-1:H]), .p(pp_lh)
    );
    soc_cpu_mult_partial #(.HALF_W(H)) u_pp_hl (
        .clk(clk), .en(advance), .a(in_src1[DATA_W-1:H]), .b(in_src2[H-1:0]), .p(pp_hl)
    );
    soc_cpu_mult_partial #(.HALF_W(H)) u_pp_hh (
        .clk(clk), .en(advance), .a(in_src1[DATA_W-1:H]), .b(in_src2[DATA_W-1:H]), .p(pp_hh)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= take;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_op  <= mult_op_e'(in_op);
            s1_tag <= in_tag;
        end
    end

    assign cross_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
    assign prod_raw  = {pp_hh, pp_ll} + {{(H-1){1'b0}}, cross_sum, {H{1'b0}}};

`ifdef SOC_CPU_MULT_UNIT_HI_EN
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   corr_in;
    logic [DATA_W-1:0]   s1_corr;
    logic [2*DATA_W-1:0] prod;

    // Signed product = unsigned product - 2^W * (neg(a) ? b : 0) - 2^W * (neg(b) ? a : 0).
    always_comb begin
        a_neg   = in_src1[DATA_W-1] &
                  ((mult_op_e'(in_op) == OP_MULXSS) | (mult_op_e'(in_op) == OP_MULXSU));
        b_neg   = in_src2[DATA_W-1] & (mult_op_e'(in_op) == OP_MULXSS);
        corr_in = (a_neg ? in_src2 : '0) + (b_neg ? in_src1 : '0);
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_corr <= corr_in;
        end
    end

    assign prod     = prod_raw - {s1_corr, {DATA_W{1'b0}}};
    assign sel_word = (s1_op == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    assign out_err  = 1'b0;
`else
    logic s2_err;
    logic unused_hi;

    assign sel_word  = prod_raw[DATA_W-1:0];
    assign unused_hi = ^prod_raw[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_err <= 1'b0;
        end else if (advance) begin
            s2_err <= (s1_op != OP_MUL);
        end
    end

    assign out_err = s2_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_result <= sel_word;
            s2_tag    <= s1_tag;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;

endmodule

// File: doc/soc_cpu_mult_unit.md
SOC_CPU_MULT_UNIT -- requirements
Module: soc_cpu_mult_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; legal values 16, 32, 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag (destination register index).
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operation request.
REQ-007 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-008 SHALL have port in_op  input  2  operation: 0 MUL, 1 MULXSS, 2 MULXSU, 3 MULXUU.
REQ-009 SHALL have port in_src1  input  DATA_W  first operand (signed for XSS, XSU).
REQ-010 SHALL have port in_src2  input  DATA_W  second operand (signed for XSS only).
REQ-011 SHALL have port in_tag  input  TAG_W  sideband, returned unchanged.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_result  output  DATA_W  selected result word.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port out_err  output  1  unsupported op flagged (see Configuration).

Function
REQ-017 SHALL transfer a request when in_valid and in_ready are both high at a rising edge; SHALL transfer a result when out_valid and out_ready are both high.
REQ-018 SHALL be a 2-stage pipeline: S1 registers four half-width partial products plus op, tag and sign corrections; S2 registers the summed 2*DATA_W product and the selected word.
REQ-019 SHALL present the result exactly 2 cycles after acceptance when out_ready stays high; sustained throughput SHALL be 1 op/cycle.
REQ-020 SHALL stall globally: advance = ~s2_valid | out_ready; in_ready = advance; when advance is low, S1 and S2 SHALL hold all contents.
REQ-021 SHALL select, for MUL, product bits [DATA_W-1:0] (signedness irrelevant); for MULX*, bits [2*DATA_W-1:DATA_W] of the signed/signed, signed/unsigned or unsigned/unsigned product.
REQ-022 SHALL compute the product modulo 2^(2*DATA_W), with no saturation or overflow flag.
REQ-023 SHALL keep out_result, out_tag and out_err stable while out_valid is high and out_ready is low.
REQ-024 SHALL accept a new request in the same cycle a result drains from a full pipeline, with no bubble.
REQ-025 SHALL drive out_valid = s2_valid; out_result and out_tag are don't-care when out_valid is low.

Reset
REQ-026 SHALL clear s1_valid and s2_valid on reset; out_valid, out_err and out_result SHALL read 0 in the cycle after reset.
REQ-027 SHALL discard in-flight operations when reset is asserted mid-operation; no result SHALL emerge from them.
REQ-028 SHALL hold in_ready low while reset is high.

Configuration
REQ-029 SHALL, with SOC_CPU_MULT_UNIT_HI_EN defined, implement all four ops and tie out_err to 0.
REQ-030 SHALL, without SOC_CPU_MULT_UNIT_HI_EN, omit high-word selection and sign-correction logic; ops 1-3 SHALL return the MUL low word with out_err=1 and unchanged latency.

Structure
REQ-031 SHALL place the op encoding enum (OP_MUL, OP_MULXSS, OP_MULXSU, OP_MULXUU) and the constant MULT_LATENCY=2 in shared package soc_cpu_mult_pkg.
REQ-032 SHALL use sub-module soc_cpu_mult_partial (unsigned DATA_W/2 x DATA_W/2 multiplier with enable-registered output), instantiated four times in S1.

Verification (DATA_W=32, HI_EN defined unless stated)
REQ-033 SHALL cover: MUL 0x0001_0003 x 0x0002_0005 -> out_result 0x000B_000F, two cycles after acceptance.
REQ-034 SHALL cover: MULXSS 0xFFFF_FFFF x 0xFFFF_FFFF -> 0x0000_0000; MULXUU with the same operands -> 0xFFFF_FFFE; MULXSU with the same operands -> 0xFFFF_FFFF.
REQ-035 SHALL cover: 8 back-to-back ops with tags 0-7 and out_ready=1 -> 8 consecutive out_valid cycles, tags in order, no bubbles.
REQ-036 SHALL cover: out_ready held low 5 cycles with a full pipeline -> in_ready=0, outputs stable; on release, both results drain in order.
REQ-037 SHALL cover: reset asserted one cycle after acceptance -> no out_valid in the following 4 cycles.
REQ-038 SHALL cover: without HI_EN, MULXUU 0x8000_0000 x 0x2 -> out_result 0x0000_0000, out_err=1.
